// File: rtl/xdbus_stream_pkg.sv
// Shared register offsets and bit positions for the xdbus_stream data-bus bridge.
package xdbus_stream_pkg;

  typedef enum logic [1:0] {
    STRM_RXDATA = 2'd0,
    STRM_TXDATA = 2'd1,
    STRM_STATUS = 2'd2,
    STRM_CTRL   = 2'd3
  } strm_off_e;

  localparam int ST_RX_EMPTY = 0;
  localparam int ST_RX_FULL  = 1;
  localparam int ST_TX_EMPTY = 2;
  localparam int ST_TX_FULL  = 3;
  localparam int ST_RX_OVF   = 4;
  localparam int ST_TX_OVF   = 5;
  localparam int ST_RX_UNF   = 6;

  localparam int ST_RX_CNT_LSB = 8;
  localparam int ST_TX_CNT_LSB = 16;
  localparam int ST_CNT_W      = 8;

  localparam int CTRL_TX_EN = 0;
  localparam int CTRL_RX_EN = 1;

endpackage

// File: rtl/xdbus_stream_xfifo_sync.sv
// Synchronous circular FIFO; silently ignores push when full and pop when empty.
module xfifo_sync #(
  parameter int DATA_W     = 32,
  parameter int DEPTH_LOG2 = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [DATA_W-1:0]     push_data,
  input  logic                  pop,
  output logic [DATA_W-1:0]     head,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  full,
  output logic                  empty
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0]   CNT_FULL = {1'b1, {DEPTH_LOG2{1'b0}}};
  localparam logic [DEPTH_LOG2:0]   CNT_ONE  = (DEPTH_LOG2+1)'(1'b1);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1'b1);

  logic [DATA_W-1:0]     mem_r [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_r;
  logic [DEPTH_LOG2-1:0] rd_ptr_r;
  logic [DEPTH_LOG2:0]   count_r;
  logic                  do_push_s;
  logic                  do_pop_s;

  assign full      = (count_r == CNT_FULL);
  assign empty     = (count_r == {(DEPTH_LOG2+1){1'b0}});
  assign count     = count_r;
  assign head      = mem_r[rd_ptr_r];
  assign do_push_s = push & ~full;
  assign do_pop_s  = pop & ~empty;

  // storage array, deliberately not reset
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_r[wr_ptr_r] <= push_data;
    end
  end

  // pointers and occupancy; pointers wrap naturally at DEPTH
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r <= {DEPTH_LOG2{1'b0}};
      rd_ptr_r <= {DEPTH_LOG2{1'b0}};
      count_r  <= {(DEPTH_LOG2+1){1'b0}};
    end else begin
      if (do_push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/xdbus_stream.sv
// Data-bus responder bridging CPU word accesses to an RX and a TX valid/ready stream.
module xdbus_stream
  import xdbus_stream_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 16,
  parameter int BASE       = 0,
  parameter int DEPTH_LOG2 = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              data_sel,
  input  logic              data_we,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [DATA_W-1:0] data_to_wr,
  output logic [DATA_W-1:0] data_to_rd,
  input  logic              rx_valid,
  output logic              rx_ready,
  input  logic [DATA_W-1:0] rx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic [DATA_W-1:0] tx_data
);

  localparam logic [ADDR_W-1:0] BASE_A = ADDR_W'(BASE);

  logic                  hit_s, rd_s, wr_s;
  strm_off_e             off_s;
  logic                  tx_en_r, rx_en_r;
  logic                  rx_ovf_r, tx_ovf_r, rx_unf_r;
  logic [DATA_W-1:0]     rx_head_s, tx_head_s;
  logic [DEPTH_LOG2:0]   rx_count_s, tx_count_s;
  logic                  rx_full_s, rx_empty_s, tx_full_s, tx_empty_s;
  logic                  rx_push_s, rx_pop_s, tx_push_s, tx_pop_s;
  logic                  rx_ovf_set_s, tx_ovf_set_s, rx_unf_set_s;
  logic                  status_wr_s, ctrl_wr_s;
  logic [DATA_W-1:0]     status_s;
  logic [DATA_W-1:0]     rd_data_s;

  assign hit_s = data_sel && (data_addr[ADDR_W-1:2] == BASE_A[ADDR_W-1:2]);
  assign off_s = strm_off_e'(data_addr[1:0]);
  assign rd_s  = hit_s & ~data_we;
  assign wr_s  = hit_s & data_we;

  assign rx_ready = rx_en_r & ~rx_full_s;
  assign tx_valid = tx_en_r & ~tx_empty_s;
  assign tx_data  = tx_head_s;

  assign rx_push_s    = rx_valid & rx_ready;
  assign rx_pop_s     = rd_s && (off_s == STRM_RXDATA) && !rx_empty_s;
  assign rx_unf_set_s = rd_s && (off_s == STRM_RXDATA) && rx_empty_s;
  assign rx_ovf_set_s = rx_valid & rx_en_r & rx_full_s;
  assign tx_push_s    = wr_s && (off_s == STRM_TXDATA);
  assign tx_ovf_set_s = tx_push_s & tx_full_s;
  assign tx_pop_s     = tx_valid & tx_ready;
  assign status_wr_s  = wr_s && (off_s == STRM_STATUS);
  assign ctrl_wr_s    = wr_s && (off_s == STRM_CTRL);

  xfifo_sync #(.DATA_W(DATA_W), .DEPTH_LOG2(DEPTH_LOG2)) u_rx_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (rx_push_s),
    .push_data (rx_data),
    .pop       (rx_pop_s),
    .head      (rx_head_s),
    .count     (rx_count_s),
    .full      (rx_full_s),
    .empty     (rx_empty_s)
  );

  xfifo_sync #(.DATA_W(DATA_W), .DEPTH_LOG2(DEPTH_LOG2)) u_tx_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (tx_push_s),
    .push_data (data_to_wr),
    .pop       (tx_pop_s),
    .head      (tx_head_s),
    .count     (tx_count_s),
    .full      (tx_full_s),
    .empty     (tx_empty_s)
  );

  // control enables and sticky flags; a same-cycle set overrides a W1C clear
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_en_r  <= 1'b0;
      rx_en_r  <= 1'b0;
      rx_ovf_r <= 1'b0;
      tx_ovf_r <= 1'b0;
      rx_unf_r <= 1'b0;
    end else begin
      if (ctrl_wr_s) begin
        tx_en_r <= data_to_wr[CTRL_TX_EN];
        rx_en_r <= data_to_wr[CTRL_RX_EN];
      end
      rx_ovf_r <= rx_ovf_set_s | (rx_ovf_r & ~(status_wr_s & data_to_wr[ST_RX_OVF]));
      tx_ovf_r <= tx_ovf_set_s | (tx_ovf_r & ~(status_wr_s & data_to_wr[ST_TX_OVF]));
      rx_unf_r <= rx_unf_set_s | (rx_unf_r & ~(status_wr_s & data_to_wr[ST_RX_UNF]));
    end
  end

  // STATUS word assembled from pre-edge state
  always_comb begin
    status_s = {DATA_W{1'b0}};
    status_s[ST_RX_EMPTY] = rx_empty_s;
    status_s[ST_RX_FULL]  = rx_full_s;
    status_s[ST_TX_EMPTY] = tx_empty_s;
    status_s[ST_TX_FULL]  = tx_full_s;
    status_s[ST_RX_OVF]   = rx_ovf_r;
    status_s[ST_TX_OVF]   = tx_ovf_r;
    status_s[ST_RX_UNF]   = rx_unf_r;
    status_s[ST_RX_CNT_LSB +: ST_CNT_W] = ST_CNT_W'(rx_count_s);
    status_s[ST_TX_CNT_LSB +: ST_CNT_W] = ST_CNT_W'(tx_count_s);
  end

  // zero-latency read mux
  always_comb begin
    rd_data_s = {DATA_W{1'b0}};
    if (rd_s) begin
      case (off_s)
        STRM_RXDATA: begin
          if (!rx_empty_s) begin
            rd_data_s = rx_head_s;
          end else begin
            rd_data_s = {DATA_W{1'b0}};
          end
        end
        STRM_TXDATA: rd_data_s = {DATA_W{1'b0}};
        STRM_STATUS: rd_data_s = status_s;
        STRM_CTRL: begin
          rd_data_s[CTRL_TX_EN] = tx_en_r;
          rd_data_s[CTRL_RX_EN] = rx_en_r;
        end
        default: rd_data_s = {DATA_W{1'b0}};
      endcase
    end else begin
      rd_data_s = {DATA_W{1'b0}};
    end
  end

  assign data_to_rd = rd_data_s;

endmodule

// File: tb/tb_xdbus_stream.sv
// Randomised self-checking bench for xdbus_stream against a queue-based behavioural model.
module tb_xdbus_stream;

  localparam int DW    = 32;
  localparam int AW    = 16;
  localparam int BASE  = 8;
  localparam int DEPTH = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          data_sel = 1'b0;
  logic          data_we = 1'b0;
  logic [AW-1:0] data_addr = '0;
  logic [DW-1:0] data_to_wr = '0;
  logic [DW-1:0] data_to_rd;
  logic          rx_valid = 1'b0;
  logic          rx_ready;
  logic [DW-1:0] rx_data = '0;
  logic          tx_valid;
  logic          tx_ready = 1'b0;
  logic [DW-1:0] tx_data;

  int n_vec = 0;
  int n_err = 0;

  // behavioural model state (post-edge view)
  logic [DW-1:0] rxq[$];
  logic [DW-1:0] txq[$];
  logic m_tx_en, m_rx_en, m_rx_ovf, m_tx_ovf, m_rx_unf;

  xdbus_stream #(.DATA_W(DW), .ADDR_W(AW), .BASE(BASE), .DEPTH_LOG2(3)) dut (
    .clk        (clk),
    .rst        (rst),
    .data_sel   (data_sel),
    .data_we    (data_we),
    .data_addr  (data_addr),
    .data_to_wr (data_to_wr),
    .data_to_rd (data_to_rd),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .rx_data    (rx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .tx_data    (tx_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] model_rd(input logic [1:0] off);
    logic [DW-1:0] s;
    s = '0;
    case (off)
      2'd0: s = (rxq.size() > 0) ? rxq[0] : '0;
      2'd2: begin
        s[0] = (rxq.size() == 0);
        s[1] = (rxq.size() == DEPTH);
        s[2] = (txq.size() == 0);
        s[3] = (txq.size() == DEPTH);
        s[4] = m_rx_ovf;
        s[5] = m_tx_ovf;
        s[6] = m_rx_unf;
        s[15:8]  = 8'(rxq.size());
        s[23:16] = 8'(txq.size());
      end
      2'd3: begin
        s[0] = m_tx_en;
        s[1] = m_rx_en;
      end
      default: s = '0;
    endcase
    return s;
  endfunction

  // compare process: checks outputs mid-cycle, then advances the model across the coming edge
  always @(negedge clk) begin
    logic hit, rd, wr, exp_rxr, exp_txv, st_wr, tx_wr;
    logic [1:0] off;
    int rs, ts;
    if (rst) begin
      rxq.delete();
      txq.delete();
      m_tx_en = 1'b0; m_rx_en = 1'b0;
      m_rx_ovf = 1'b0; m_tx_ovf = 1'b0; m_rx_unf = 1'b0;
    end else begin
      rs  = rxq.size();
      ts  = txq.size();
      off = data_addr[1:0];
      hit = data_sel && ((data_addr >> 2) == (AW'(BASE) >> 2));
      rd  = hit && !data_we;
      wr  = hit && data_we;
      exp_rxr = m_rx_en && (rs < DEPTH);
      exp_txv = m_tx_en && (ts > 0);
      chk("data_to_rd", data_to_rd, rd ? model_rd(off) : '0);
      chk("rx_ready", {31'b0, rx_ready}, {31'b0, exp_rxr});
      chk("tx_valid", {31'b0, tx_valid}, {31'b0, exp_txv});
      if (ts > 0) chk("tx_data", tx_data, txq[0]);

      st_wr = wr && (off == 2'd2);
      tx_wr = wr && (off == 2'd1);
      m_rx_ovf = (rx_valid && m_rx_en && rs == DEPTH) || (m_rx_ovf && !(st_wr && data_to_wr[4]));
      m_tx_ovf = (tx_wr && ts == DEPTH) || (m_tx_ovf && !(st_wr && data_to_wr[5]));
      m_rx_unf = (rd && off == 2'd0 && rs == 0) || (m_rx_unf && !(st_wr && data_to_wr[6]));
      if (rd && off == 2'd0 && rs > 0) void'(rxq.pop_front());
      if (rx_valid && exp_rxr) rxq.push_back(rx_data);
      if (exp_txv && tx_ready) void'(txq.pop_front());
      if (tx_wr && ts < DEPTH) txq.push_back(data_to_wr);
      if (wr && off == 2'd3) begin
        m_tx_en = data_to_wr[0];
        m_rx_en = data_to_wr[1];
      end
    end
  end

  task automatic bus(input logic sel, input logic we, input logic [1:0] off, input logic [DW-1:0] wd);
    @(posedge clk);
    #1;
    data_sel   = sel;
    data_we    = we;
    data_addr  = AW'(BASE) + {14'b0, off};
    data_to_wr = wd;
  endtask

  task automatic idle();
    bus(1'b0, 1'b0, 2'd0, '0);
  endtask

  task automatic wr(input logic [1:0] off, input logic [DW-1:0] wd);
    bus(1'b1, 1'b1, off, wd);
  endtask

  task automatic rd_lit(input string name, input logic [1:0] off, input logic [DW-1:0] exp);
    bus(1'b1, 1'b0, off, '0);
    #2;
    chk(name, data_to_rd, exp);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // reset state and empty-read underflow
    rd_lit("status_reset", 2'd2, 32'h0000_0005);
    chk("rx_ready_reset", {31'b0, rx_ready}, 32'h0);
    chk("tx_valid_reset", {31'b0, tx_valid}, 32'h0);
    rd_lit("rxdata_empty", 2'd0, 32'h0);
    rd_lit("status_unf", 2'd2, 32'h0000_0045);
    rd_lit("ctrl_reset", 2'd3, 32'h0);
    rd_lit("txdata_read", 2'd1, 32'h0);

    // RX ordering
    wr(2'd2, 32'h70);
    wr(2'd3, 32'h3);
    idle(); rx_valid = 1'b1; rx_data = 32'h11;
    idle(); rx_data = 32'h22;
    idle(); rx_data = 32'h33;
    idle(); rx_valid = 1'b0;
    rd_lit("status_rx3", 2'd2, 32'h0000_0304);
    rd_lit("rx_0", 2'd0, 32'h11);
    rd_lit("rx_1", 2'd0, 32'h22);
    rd_lit("rx_2", 2'd0, 32'h33);
    rd_lit("status_rx0", 2'd2, 32'h0000_0005);

    // TX fill past full, then drain
    wr(2'd3, 32'h1);
    for (int i = 0; i < 9; i++) wr(2'd1, 32'h100 + 32'(i));
    rd_lit("status_txfull", 2'd2, 32'h0008_0029);
    for (int i = 0; i < 8; i++) begin
      idle(); tx_ready = 1'b1; #2;
      chk("tx_drain_valid", {31'b0, tx_valid}, 32'h1);
      chk("tx_drain_data", tx_data, 32'h100 + 32'(i));
    end
    idle(); tx_ready = 1'b0; #2;
    chk("tx_drained", {31'b0, tx_valid}, 32'h0);

    // pointer wrap through RX with concurrent push/pop
    wr(2'd2, 32'h70);
    wr(2'd3, 32'h3);
    idle(); rx_valid = 1'b1; rx_data = 32'h200;
    for (int i = 1; i < 20; i++) begin
      bus(1'b1, 1'b0, 2'd0, '0); rx_data = 32'h200 + 32'(i); #2;
      chk("wrap_data", data_to_rd, 32'h200 + 32'(i - 1));
    end
    bus(1'b1, 1'b0, 2'd0, '0); rx_valid = 1'b0; #2;
    chk("wrap_last", data_to_rd, 32'h213);
    rd_lit("status_wrap", 2'd2, 32'h0000_0005);

    // RX overflow, W1C, set-beats-clear
    for (int i = 0; i < 8; i++) begin
      idle(); rx_valid = 1'b1; rx_data = 32'h300 + 32'(i);
    end
    idle(); #2;
    chk("rx_ready_full", {31'b0, rx_ready}, 32'h0);
    bus(1'b1, 1'b0, 2'd2, '0); rx_valid = 1'b0; #2;
    chk("status_rxovf", data_to_rd, 32'h0000_0816);
    wr(2'd2, 32'h70);
    rd_lit("status_cleared", 2'd2, 32'h0000_0806);
    wr(2'd2, 32'h70); rx_valid = 1'b1;
    bus(1'b1, 1'b0, 2'd2, '0); rx_valid = 1'b0; #2;
    chk("status_setwins", data_to_rd, 32'h0000_0816);

    // reset with queued words
    wr(2'd3, 32'h2);
    for (int i = 0; i < 4; i++) wr(2'd1, 32'hdead_0000 + 32'(i));
    idle(); rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0; #2;
    chk("tx_valid_after_rst", {31'b0, tx_valid}, 32'h0);
    chk("rx_ready_after_rst", {31'b0, rx_ready}, 32'h0);
    rd_lit("status_after_rst", 2'd2, 32'h0000_0005);
    rd_lit("ctrl_after_rst", 2'd3, 32'h0);
    wr(2'd3, 32'h1);
    wr(2'd1, 32'hab);
    idle(); #2;
    chk("tx_head_fresh", tx_data, 32'hab);
    chk("tx_valid_fresh", {31'b0, tx_valid}, 32'h1);

    // randomised traffic
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #1;
      rst        = ($urandom_range(0, 599) == 0);
      data_sel   = ($urandom_range(0, 3) != 0);
      data_we    = $urandom_range(0, 1) == 1;
      data_addr  = ($urandom_range(0, 9) == 0) ? AW'($urandom) : AW'(BASE) + AW'($urandom_range(0, 3));
      data_to_wr = ($urandom_range(0, 1) == 1) ? 32'(3) : $urandom;
      rx_valid   = $urandom_range(0, 2) != 0;
      rx_data    = $urandom;
      tx_ready   = $urandom_range(0, 2) != 0;
    end
    @(posedge clk); #1;
    rst = 1'b0; data_sel = 1'b0; rx_valid = 1'b0; tx_ready = 1'b0;
    repeat (2) @(posedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
